// File: rtl/render_burst_writer.sv
// Render-side DDR2 write path: packs renderer points into MCB port-0 write bursts
// and ping-pongs between two frame buffers, handing the finished one to the reader.
module render_burst_writer #(
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned FRAME_WORDS = 921600,
  parameter logic [29:0] FRAME0_BASE = 30'h0000000,
  parameter logic [29:0] FRAME1_BASE = 30'h0400000
) (
  input  logic        clk,
  input  logic        SYS_RESETn,
  input  logic        mem_calib_done,
  input  logic [31:0] pt_data,
  input  logic        pt_ready,
  output logic        pt_send,
  input  logic        render_reset,
  output logic        wr_en,
  output logic [31:0] wr_data,
  input  logic        wr_full,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic        cmd_full,
  output logic        display_frame,
  output logic        frame_ready
);

  localparam int FCW = $clog2(FRAME_WORDS + 1);
  localparam logic [6:0]     BURST_MAX = 7'(BURST_LEN);
  localparam logic [FCW-1:0] FRAME_MAX = FCW'(FRAME_WORDS);

  typedef enum logic [1:0] {IDLE, FILL, CMD, SWAP} state_e;

  state_e         state_q, state_d;
  logic [6:0]     burst_q, burst_d;
  logic [FCW-1:0] frame_q, frame_d;
  logic [29:0]    addr_q, addr_d;
  logic           wframe_q, wframe_d;
  logic           dframe_q, dframe_d;
  logic           rrpend_q, rrpend_d;

  logic rr_eff;
  logic pop;
  logic burst_done;
  logic frame_done;

  assign rr_eff     = render_reset | rrpend_q;
  assign burst_done = (burst_q == BURST_MAX);
  assign frame_done = (frame_q == FRAME_MAX);

  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mem_calib_done) state_d = FILL;
      FILL: begin
        if (burst_done || frame_done || ((rr_eff || !mem_calib_done) && burst_q != '0))
          state_d = CMD;
        else if (!mem_calib_done)
          state_d = IDLE;
      end
      CMD: begin
        if (!cmd_full) begin
          if (frame_done)          state_d = SWAP;
          else if (mem_calib_done) state_d = FILL;
          else                     state_d = IDLE;
        end
      end
      SWAP:    state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  // A pending restart takes precedence over popping, so no point from the new
  // frame pass leaks into the burst being flushed for the old one.
  always_comb begin
    pop = (state_q == FILL) && pt_ready && !wr_full && mem_calib_done && !rr_eff &&
          (burst_q < BURST_MAX) && (frame_q < FRAME_MAX);
    pt_send       = pop;
    wr_en         = pop;
    wr_data       = pop ? pt_data : 32'h0;
    cmd_en        = (state_q == CMD) && !cmd_full;
    cmd_instr     = 3'b000;
    cmd_bl        = cmd_en ? 6'(burst_q - 7'd1) : 6'h0;
    cmd_byte_addr = addr_q;
    frame_ready   = (state_q == SWAP);
    display_frame = dframe_q;
  end

  always_comb begin
    burst_d  = burst_q;
    frame_d  = frame_q;
    addr_d   = addr_q;
    wframe_d = wframe_q;
    dframe_d = dframe_q;
    rrpend_d = rrpend_q;
    if (render_reset && !(state_q == FILL && burst_q == '0))
      rrpend_d = 1'b1;
    case (state_q)
      FILL: begin
        if (rr_eff && burst_q == '0) begin
          addr_d   = wframe_q ? FRAME1_BASE : FRAME0_BASE;
          frame_d  = '0;
          rrpend_d = 1'b0;
        end else if (pop) begin
          burst_d = burst_q + 7'd1;
          frame_d = frame_q + FCW'(1);
        end
      end
      CMD: begin
        if (cmd_en) begin
          addr_d  = addr_q + 30'({burst_q, 2'b00});
          burst_d = '0;
        end
      end
      SWAP: begin
        dframe_d = wframe_q;
        wframe_d = ~wframe_q;
        addr_d   = wframe_q ? FRAME0_BASE : FRAME1_BASE;
        frame_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn) begin
      burst_q  <= '0;
      frame_q  <= '0;
      addr_q   <= FRAME0_BASE;
      wframe_q <= 1'b0;
      dframe_q <= 1'b1;
      rrpend_q <= 1'b0;
    end else begin
      burst_q  <= burst_d;
      frame_q  <= frame_d;
      addr_q   <= addr_d;
      wframe_q <= wframe_d;
      dframe_q <= dframe_d;
      rrpend_q <= rrpend_d;
    end
  end

endmodule
